ram_arbiter: RTL
================

# ram_arbiter

Round-robin arbiter that shares one single-port synchronous `ram` instance among `NREQ` requesters. Each requester issues single-word read or write requests over a valid/ready handshake. The arbiter grants at most one request per cycle and drives the RAM port. It then routes the RAM's registered read data back to the granted requester one cycle later. It sits between the core-side agents (fetch, load/store, DMA) and the shared RAM.

## Interface
- `WIDTH`, 8: data word width; must match the RAM.
- `DEPTH`, 256: RAM depth; `AW = $clog2(DEPTH)`.
- `NREQ`, 2: number of requesters; must be ≥ 2.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_we` in NREQ: 1 = write, 0 = read, per requester.
- `req_addr` in NREQ*AW: packed addresses; requester i occupies `[i*AW +: AW]`.
- `req_wdata` in NREQ*WIDTH: packed write data; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_ready` out NREQ: one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out NREQ: one-hot; read data for requester i is valid this cycle.
- `rsp_rdata` out WIDTH: read data, shared by all requesters, qualified by `rsp_valid`.
- `ram_we` out 1: to RAM `we`.
- `ram_addr` out AW: to RAM `addr`.
- `ram_data_in` out WIDTH: to RAM `data_in`.
- `ram_data_out` in WIDTH: from RAM `data_out`.

## Operation
- **RAM model:**
  - Write happens at the clock edge.
  - Read data appears on `ram_data_out` after the edge at which the address was presented.
  - A read at the same edge as a write to the same address returns the old contents.
  - The RAM clears all contents and `data_out` on `rst`.
- **Priority pointer:** `ptr`, range 0..NREQ-1, registered, resets to 0.
- **Grant selection (combinational):**
  - Search `req_valid` starting at index `ptr`, wrapping modulo NREQ.
  - The first set bit is the granted index `g`, and `req_ready[g] = 1`.
  - All other `req_ready` bits are 0. If no request is valid, all bits are 0.
  - `req_ready` depends only on `req_valid` and `ptr`, never on `req_we` or `req_addr`.
- **Pointer update:** on a grant, `ptr <= (g+1) mod NREQ`. With no grant, `ptr` holds.
- **RAM drive when granted:**
  - `ram_we = req_we[g]`
  - `ram_addr = req_addr[g]`
  - `ram_data_in = req_wdata[g]`
- **RAM drive when idle:** `ram_we = 0`, `ram_addr = 0`, `ram_data_in = 0`.
- **Response tracking:** registered `rd_pend` (1 bit) and `rd_id` (index).
  - On a read grant, set `rd_pend = 1` and `rd_id = g`. Otherwise `rd_pend = 0`.
  - `rsp_valid[rd_id] = rd_pend`; all other bits are 0.
  - `rsp_rdata = ram_data_out`, passed through combinationally.
- **Write responses:** writes produce no response. The requester treats acceptance as completion.
- **Fairness:** any requester holding `req_valid` is granted within NREQ cycles.
- **Requester rules:**
  - A requester must hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until accepted.
  - A requester may drop `req_valid` before acceptance; the arbiter then never grants that request.
- **Read-after-write ordering:** within one requester, a write accepted at cycle N followed by a read accepted at cycle M > N returns the written data.
- **Cross-requester same-cycle conflicts:** resolved purely by grant order; there is no address-conflict logic.

## Timing
- **Reset values:** while `rst = 1`, all outputs are 0:
  - `req_ready`, `rsp_valid`, `ram_we`, `ram_addr`, `ram_data_in` are forced to 0.
  - `rsp_rdata` is 0 because the RAM clears `data_out`.
  - `ptr`, `rd_pend` and `rd_id` are reset to 0.
- **Throughput:** one access per cycle, with back-to-back grants to any mix of requesters.
- **Read latency:** a read accepted in cycle N has `rsp_valid` and `rsp_rdata` in cycle N+1, for exactly one cycle. There is no response backpressure.
- **Reset mid-operation:** a read accepted in the cycle before `rst` rises gets no response. The first grant after `rst` falls uses `ptr = 0`.
- **Single requester:** a requester that is the only valid one is granted every cycle, regardless of `ptr`.

## Test plan
- **Reset:** assert `rst` with all `req_valid` = 1. Required: all outputs 0. After release, the first grant goes to requester 0.
- **Write then read, requester 0:** write `0x10 ← 0xA5`, then read `0x10`. Required: `rsp_valid = 01` one cycle after the read grant, with `rsp_rdata = 0xA5`. The write produces no `rsp_valid`.
- **Round-robin, NREQ = 2:** both requesters issue continuous reads. Required: `req_ready` alternates 01, 10, 01, …, and each `rsp_valid` follows its grant by one cycle with the correct data.
- **Same-cycle conflict on address `0x20` (initially `0x00`):** requester 0 reads `0x20` while requester 1 writes `0x3C` to it.
  - With `ptr = 0`: the read returns `0x00`.
  - With `ptr = 1`: the write goes first, then the read returns `0x3C`.
- **Reset mid-read:** pulse `rst` in the cycle after a read grant. Required: `rsp_valid` stays 0. A subsequent read of a previously written address returns `0x00`.
- **NREQ = 4, only requesters 2 and 3 valid:** required grants alternate 2, 3, 2, 3. When all requests drop, `ram_we = 0` and `ram_addr = 0`.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NREQ requesters.
// Grants at most one access per cycle and returns read data to the granted requester one cycle later.
module ram_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned NREQ  = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [WIDTH-1:0]      ram_data_in,
  input  logic [WIDTH-1:0]      ram_data_out
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = IW + 1;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [IW-1:0]    rd_id_q, rd_id_d;

  logic             gnt_c;
  logic [IW-1:0]    gnt_idx_c;
  logic             sel_we_c;
  logic [AW-1:0]    sel_addr_c;
  logic [WIDTH-1:0] sel_wdata_c;

  // Rotating priority search starting at ptr, wrapping modulo NREQ
  always_comb begin
    logic [SW-1:0] cand;
    gnt_c     = 1'b0;
    gnt_idx_c = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + SW'(k);
      if (cand >= SW'(NREQ)) begin
        cand = cand - SW'(NREQ);
      end
      if (!gnt_c && req_valid[cand[IW-1:0]]) begin
        gnt_c     = 1'b1;
        gnt_idx_c = cand[IW-1:0];
      end
    end
  end

  // Select the granted requester's command fields
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c && (gnt_idx_c == IW'(i))) begin
        sel_we_c    = req_we[i];
        sel_addr_c  = req_addr[i*AW +: AW];
        sel_wdata_c = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant and RAM port drive; everything reads as zero while reset is held
  always_comb begin
    req_ready   = '0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (!rst && gnt_c) begin
      req_ready[gnt_idx_c] = 1'b1;
      ram_we               = sel_we_c;
      ram_addr             = sel_addr_c;
      ram_data_in          = sel_wdata_c;
    end
  end

  // Pointer advance past the winner and read-response tracking
  always_comb begin
    logic [SW-1:0] nxt;
    ptr_d     = ptr_q;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    nxt       = '0;
    if (gnt_c) begin
      nxt = {1'b0, gnt_idx_c} + SW'(1);
      if (nxt >= SW'(NREQ)) begin
        nxt = '0;
      end
      ptr_d = nxt[IW-1:0];
      if (!sel_we_c) begin
        rd_pend_d = 1'b1;
        rd_id_d   = gnt_idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // Response steering: RAM data is already registered, so it passes straight through
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!rst && rd_pend_q && (rd_id_q == IW'(i))) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_rdata = ram_data_out;

endmodule
